// File: rtl/demux_deser_pkg.sv
// Shared constants, output FSM states and the round-robin picker for the
// demux channel deserializer.
package demux_deser_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Returns {found, channel}: the first requesting channel strictly after 'last', wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [SEL_W-1:0]  last);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/demux_chan_deserializer_if.sv
// Bit-stream input and word output bundle of the demux channel deserializer.
interface demux_chan_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]       Yin;
    logic [1:0]       S;
    logic             Vin;
    logic             Flush;
    logic [WIDTH-1:0] Dout;
    logic [1:0]       Ch;
    logic             Vout;
    logic             Rdy;
    logic [3:0]       Ovf;

    modport master (
        output Yin, S, Vin, Flush, Rdy,
        input  Dout, Ch, Vout, Ovf
    );

    modport slave (
        input  Yin, S, Vin, Flush, Rdy,
        output Dout, Ch, Vout, Ovf
    );
endinterface

// File: rtl/demux_chan_deserializer_slice.sv
// One channel: MSB-first shift register, bit counter, single-word hold buffer
// and sticky overflow flag.
module demux_chan_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit,
    input  logic             i_strobe,
    input  logic             i_flush,
    input  logic             i_drain,
    output logic [WIDTH-1:0] o_word,
    output logic             o_hold_v,
    output logic             o_ovf
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-2:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_v;
    logic             r_ovf;
    logic [WIDTH-1:0] w_shifted;
    logic             w_done;

    assign w_shifted = {r_sh, i_bit};
    assign w_done    = i_strobe && !i_flush && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_strobe) begin
            r_sh  <= w_shifted[WIDTH-2:0];
            r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // A drain in the same cycle frees the buffer for the word completing now.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_done && (!r_hold_v || i_drain)) begin
                r_hold   <= w_shifted;
                r_hold_v <= 1'b1;
            end else if (i_drain) begin
                r_hold_v <= 1'b0;
            end
            if (w_done && r_hold_v && !i_drain)
                r_ovf <= 1'b1;
        end
    end

    assign o_word   = r_hold;
    assign o_hold_v = r_hold_v;
    assign o_ovf    = r_ovf;
endmodule

// File: rtl/demux_chan_deserializer.sv
// Four per-channel word assemblers feeding one valid/ready output port,
// arbitrated round-robin.
module demux_chan_deserializer
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic Clk,
    input logic Rst,
    demux_chan_deserializer_if.slave bus
);
    logic [WIDTH-1:0]  w_word [NUM_CH];
    logic [NUM_CH-1:0] w_hold_v;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_drain;
    logic              w_bit;
    logic              w_found;
    logic [SEL_W-1:0]  w_pick;
    logic              w_load;
    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_dout;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  r_rr;

    assign w_bit = bus.Yin[bus.S];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
        demux_chan_slice #(.WIDTH(WIDTH)) u_slice (
            .i_clk    (Clk),
            .i_rst    (Rst),
            .i_bit    (w_bit),
            .i_strobe (bus.Vin && (bus.S == SEL_W'(i))),
            .i_flush  (bus.Flush),
            .i_drain  (w_drain[i]),
            .o_word   (w_word[i]),
            .o_hold_v (w_hold_v[i]),
            .o_ovf    (w_ovf[i])
        );
    end

    // In SEND a new word is loaded only when the current one is being accepted.
    always_comb begin
        {w_found, w_pick} = rr_pick(w_hold_v, r_rr);
        w_load  = w_found && ((r_state == ST_IDLE) || bus.Rdy);
        w_drain = '0;
        if (w_load)
            w_drain[w_pick] = 1'b1;
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_next = ST_SEND;
            ST_SEND: if (bus.Rdy && !w_found) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_dout <= '0;
            r_ch   <= '0;
            r_rr   <= SEL_W'(NUM_CH - 1);
        end else if (w_load) begin
            r_dout <= w_word[w_pick];
            r_ch   <= w_pick;
            r_rr   <= w_pick;
        end
    end

    assign bus.Dout = r_dout;
    assign bus.Ch   = r_ch;
    assign bus.Vout = (r_state == ST_SEND);
    assign bus.Ovf  = w_ovf;
endmodule

// File: tb/tb_demux_chan_deserializer.sv
// Directed scenarios plus random traffic, checked each cycle against an
// integer-level reference model of the deserializer.
module tb_demux_chan_deserializer;
    localparam int unsigned WIDTH = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    demux_chan_deserializer_if #(.WIDTH(WIDTH)) bus ();

    demux_chan_deserializer #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int       m_val  [4];
    int       m_cnt  [4];
    int       m_hold [4];
    bit       m_hv   [4];
    bit [3:0] m_ovf;
    bit       m_v;
    int       m_d;
    int       m_c;
    int       m_rr;

    logic [9:0] got[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_val[c] = 0; m_cnt[c] = 0; m_hold[c] = 0; m_hv[c] = 0;
        end
        m_ovf = '0; m_v = 0; m_d = 0; m_c = 0; m_rr = 3;
    endtask

    task automatic model_step(input bit vin, input int s, input bit b, input bit fl, input bit rdy);
        int p = -1;
        int hd = 0;
        bit load;
        for (int k = 1; k <= 4; k++)
            if (p < 0 && m_hv[(m_rr + k) % 4]) p = (m_rr + k) % 4;
        load = (p >= 0) && (!m_v || rdy);
        if (load) begin
            hd = m_hold[p];
            m_hv[p] = 0;
        end
        if (fl) begin
            for (int c = 0; c < 4; c++) begin m_val[c] = 0; m_cnt[c] = 0; end
        end else if (vin) begin
            m_val[s] = (m_val[s] * 2 + int'(b)) % 256;
            m_cnt[s]++;
            if (m_cnt[s] == WIDTH) begin
                m_cnt[s] = 0;
                if (!m_hv[s]) begin
                    m_hold[s] = m_val[s];
                    m_hv[s] = 1;
                end else begin
                    m_ovf[s] = 1'b1;
                end
            end
        end
        if (load) begin
            m_d = hd; m_c = p; m_rr = p; m_v = 1;
        end else if (m_v && rdy) begin
            m_v = 0;
        end
    endtask

    // Called at a negedge: drive, clock, update model, compare at next negedge.
    task automatic step(input bit vin, input int s, input bit b, input bit fl, input bit rdy);
        logic [3:0] y;
        y = 4'($urandom);
        y[s] = b;
        bus.Yin = y; bus.S = 2'(s); bus.Vin = vin; bus.Flush = fl; bus.Rdy = rdy;
        #1;
        if (bus.Vout && rdy) got.push_back({bus.Ch, bus.Dout});
        @(posedge Clk);
        model_step(vin, s, b, fl, rdy);
        @(negedge Clk);
        chk("vout", 32'(bus.Vout), 32'(m_v));
        chk("ovf",  32'(bus.Ovf),  32'(m_ovf));
        chk("dout", 32'(bus.Dout), 32'(m_d));
        chk("ch",   32'(bus.Ch),   32'(m_c));
    endtask

    task automatic send_word(input int ch, input logic [7:0] w, input bit rdy, input bit rdy_last);
        for (int i = 7; i >= 0; i--)
            step(1'b1, ch, w[i], 1'b0, (i == 0) ? rdy_last : rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, rdy);
    endtask

    task automatic expect_word(input string tag, input logic [9:0] exp);
        logic [9:0] w;
        w = (got.size() > 0) ? got.pop_front() : 10'h3ff;
        chk(tag, 32'(w), 32'(exp));
    endtask

    initial begin
        bus.Yin = '0; bus.S = '0; bus.Vin = 1'b0; bus.Flush = 1'b0; bus.Rdy = 1'b0;
        model_reset();
        @(negedge Clk); @(negedge Clk);
        chk("rst_vout", 32'(bus.Vout), 0);
        chk("rst_dout", 32'(bus.Dout), 0);
        chk("rst_ch",   32'(bus.Ch),   0);
        chk("rst_ovf",  32'(bus.Ovf),  0);
        Rst = 1'b0;

        // 1: single word, latency and one-cycle valid
        send_word(2, 8'hA5, 1'b1, 1'b1);
        chk("t1_vout_n1", 32'(bus.Vout), 0);
        idle(1, 1'b1);
        chk("t1_vout_n2", 32'(bus.Vout), 1);
        chk("t1_dout", 32'(bus.Dout), 32'h A5);
        chk("t1_ch",   32'(bus.Ch), 2);
        idle(1, 1'b1);
        chk("t1_vout_drop", 32'(bus.Vout), 0);
        expect_word("t1_word", {2'd2, 8'hA5});
        chk("t1_left", got.size(), 0);

        // 2: interleaved channels, held while Rdy=0
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a, c;
            a = 8'h3C; c = 8'hC3;
            step(1'b1, 0, a[i], 1'b0, 1'b0);
            step(1'b1, 1, c[i], 1'b0, 1'b0);
        end
        idle(4, 1'b0);
        chk("t2_hold_dout", 32'(bus.Dout), 32'h3C);
        idle(4, 1'b1);
        expect_word("t2_w0", {2'd0, 8'h3C});
        expect_word("t2_w1", {2'd1, 8'hC3});
        chk("t2_left", got.size(), 0);

        // 3: overflow on ch3
        send_word(3, 8'h11, 1'b0, 1'b0);
        send_word(3, 8'h22, 1'b0, 1'b0);
        send_word(3, 8'h33, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t3_ovf", 32'(bus.Ovf), 32'b1000);
        idle(4, 1'b1);
        expect_word("t3_w0", {2'd3, 8'h11});
        expect_word("t3_w1", {2'd3, 8'h22});
        chk("t3_left", got.size(), 0);
        chk("t3_ovf_sticky", 32'(bus.Ovf), 32'b1000);

        // 4: flush discards partial word
        for (int i = 0; i < 5; i++) step(1'b1, 1, 1'($urandom), 1'b0, 1'b1);
        step(1'b1, 1, 1'b1, 1'b1, 1'b1);
        send_word(1, 8'hF0, 1'b1, 1'b1);
        idle(3, 1'b1);
        expect_word("t4_w", {2'd1, 8'hF0});
        chk("t4_left", got.size(), 0);

        // 5: completion on ch0 in the same cycle hold[0] drains
        send_word(0, 8'h81, 1'b0, 1'b0);
        send_word(0, 8'h42, 1'b0, 1'b0);
        send_word(0, 8'h24, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("t5_no_ovf0", 32'(bus.Ovf[0]), 0);
        expect_word("t5_w0", {2'd0, 8'h81});
        expect_word("t5_w1", {2'd0, 8'h42});
        expect_word("t5_w2", {2'd0, 8'h24});
        chk("t5_left", got.size(), 0);

        // 6: async reset while Vout=1 and mid-word
        send_word(2, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'($urandom), 1'b0, 1'b0);
        chk("t6_pre_vout", 32'(bus.Vout), 1);
        Rst = 1'b1;
        #1;
        chk("t6_vout", 32'(bus.Vout), 0);
        chk("t6_dout", 32'(bus.Dout), 0);
        chk("t6_ch",   32'(bus.Ch), 0);
        chk("t6_ovf",  32'(bus.Ovf), 0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        send_word(0, 8'h5A, 1'b1, 1'b1);
        idle(3, 1'b1);
        expect_word("t6_w", {2'd0, 8'h5A});
        chk("t6_left", got.size(), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom),
                 ($urandom % 64) == 0, ($urandom % 3) != 0);
        got.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
